// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-to-read forwarding and a
// per-register pending bit used for issue/writeback hazard tracking.
module regfile_mp_scoreboard #(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 32,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*AW-1:0]      rd_addr,
  output logic [NREAD*XLEN-1:0]    rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*AW-1:0]     wr_addr,
  input  logic [NWRITE*XLEN-1:0]   wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     flush,
  output logic                     pend_any
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] pend_r;
  logic [NREGS-1:0] wr_hit_s;
  logic [XLEN-1:0]  wr_val_s [NREGS];
  logic [NREGS-1:0] pend_nxt_s;

  // Per-register write decode; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit_s[r] = 1'b0;
      wr_val_s[r] = {XLEN{1'b0}};
      for (int j = 0; j < NWRITE; j++) begin
        wr_hit_s[r] = wr_hit_s[r] |
                      (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)) && (r != 0));
        wr_val_s[r] = (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)) && (r != 0)) ?
                      wr_data[j*XLEN +: XLEN] : wr_val_s[r];
      end
    end
  end

  // Read mux with same-cycle forwarding; a forwarded value is never busy.
  always_comb begin : rd_mux
    logic [AW-1:0]   ra_s;
    logic            fwd_s;
    logic [XLEN-1:0] val_s;
    ra_s    = {AW{1'b0}};
    fwd_s   = 1'b0;
    val_s   = {XLEN{1'b0}};
    rd_data = {(NREAD*XLEN){1'b0}};
    rd_busy = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      ra_s  = rd_addr[i*AW +: AW];
      fwd_s = 1'b0;
      val_s = regs_r[ra_s];
      for (int j = 0; j < NWRITE; j++) begin
        fwd_s = fwd_s | (wr_en[j] && (wr_addr[j*AW +: AW] == ra_s));
        val_s = (wr_en[j] && (wr_addr[j*AW +: AW] == ra_s)) ? wr_data[j*XLEN +: XLEN] : val_s;
      end
      if (rst || (ra_s == {AW{1'b0}})) begin
        rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = val_s;
        rd_busy[i]              = pend_r[ra_s] & ~fwd_s;
      end
    end
  end

  // Pending next state: flush clears everything, issue beats a same-cycle writeback.
  always_comb begin
    pend_nxt_s = {NREGS{1'b0}};
    if (flush) begin
      pend_nxt_s = {NREGS{1'b0}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_nxt_s[r] = (iss_en && (iss_addr == AW'(r)) && (r != 0)) ? 1'b1 :
                        (wr_hit_s[r] ? 1'b0 : pend_r[r]);
      end
    end
  end

  // Architectural state; register 0 is never written and stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
      pend_r <= {NREGS{1'b0}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit_s[r]) begin
          regs_r[r] <= wr_val_s[r];
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
      pend_r <= pend_nxt_s;
    end
  end

  assign pend_any = |pend_r;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Self-checking bench: directed vector table, reset/collision sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_mp_scoreboard;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic              pend_any;

  int n_total = 0;
  int n_pass = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_pend [NREGS];

  regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      wen;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            iss;
    logic [AW-1:0]   ia;
    logic            fl;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] ed0, ed1;
    logic            eb0, eb1, epa;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [1:0] wen, input int wa0, input logic [XLEN-1:0] wd0,
                              input int wa1, input logic [XLEN-1:0] wd1, input logic iss, input int ia,
                              input logic fl, input int ra0, input int ra1,
                              input logic [XLEN-1:0] ed0, input logic [XLEN-1:0] ed1,
                              input logic eb0, input logic eb1, input logic epa);
    vec_t v;
    v.wen = wen; v.wa0 = AW'(wa0); v.wd0 = wd0; v.wa1 = AW'(wa1); v.wd1 = wd1;
    v.iss = iss; v.ia = AW'(ia); v.fl = fl; v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.epa = epa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // Expected read result straight from the architectural rules.
  task automatic exp_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    logic fwd;
    fwd = 1'b0;
    d = m_regs[a];
    b = m_pend[a];
    for (int j = 0; j < 2; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
        fwd = 1'b1;
        d = wr_data[j*XLEN +: XLEN];
      end
    end
    if (fwd) b = 1'b0;
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  function automatic logic m_any();
    logic a = 1'b0;
    for (int r = 0; r < NREGS; r++) a |= m_pend[r];
    return a;
  endfunction

  // Apply the current inputs to the model as the clock edge would.
  task automatic model_commit();
    for (int j = 0; j < 2; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    if (flush) begin
      for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) m_pend[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic edge_step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    logic [XLEN-1:0] d0, d1;
    logic b0, b1;
    exp_read(rd_addr[AW-1:0], d0, b0);
    exp_read(rd_addr[2*AW-1:AW], d1, b1);
    chk({tag, "_d0"}, rd_data[XLEN-1:0], d0);
    chk({tag, "_d1"}, rd_data[2*XLEN-1:XLEN], d1);
    chk({tag, "_b0"}, XLEN'(rd_busy[0]), XLEN'(b0));
    chk({tag, "_b1"}, XLEN'(rd_busy[1]), XLEN'(b1));
    chk({tag, "_pany"}, XLEN'(pend_any), XLEN'(m_any()));
  endtask

  initial begin
    //          wen    wa0 wd0      wa1 wd1     iss ia  fl  ra0 ra1 ed0      ed1   eb0 eb1 epa
    tbl[0]  = mk(2'b11, 7, 64'h11,   7, 64'h22, 0,  0,  0,  7,  0, 64'h22,  64'h0, 0, 0, 0);
    tbl[1]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  7,  7, 64'h22,  64'h22, 0, 0, 0);
    tbl[2]  = mk(2'b01, 0, 64'hFFFF, 0, 64'h0,  1,  0,  0,  0,  7, 64'h0,   64'h22, 0, 0, 0);
    tbl[3]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  0,  7, 64'h0,   64'h22, 0, 0, 0);
    tbl[4]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  1,  9,  0,  9,  0, 64'h0,   64'h0, 0, 0, 0);
    tbl[5]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  9,  0, 64'h0,   64'h0, 1, 0, 1);
    tbl[6]  = mk(2'b01, 9, 64'h5,    0, 64'h0,  0,  0,  0,  9,  0, 64'h5,   64'h0, 0, 0, 1);
    tbl[7]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  9,  0, 64'h5,   64'h0, 0, 0, 0);
    tbl[8]  = mk(2'b00, 0, 64'h0,    0, 64'h0,  1,  3,  0,  3,  0, 64'h0,   64'h0, 0, 0, 0);
    tbl[9]  = mk(2'b10, 0, 64'h0,    3, 64'hA,  1,  3,  0,  3,  0, 64'hA,   64'h0, 0, 0, 1);
    tbl[10] = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  3,  0, 64'hA,   64'h0, 1, 0, 1);
    tbl[11] = mk(2'b00, 0, 64'h0,    0, 64'h0,  1,  4,  0,  4,  0, 64'h0,   64'h0, 0, 0, 1);
    tbl[12] = mk(2'b00, 0, 64'h0,    0, 64'h0,  1,  8,  0,  4,  8, 64'h0,   64'h0, 1, 0, 1);
    tbl[13] = mk(2'b00, 0, 64'h0,    0, 64'h0,  1, 12,  1,  4,  8, 64'h0,   64'h0, 1, 1, 1);
    tbl[14] = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0, 12,  8, 64'h0,   64'h0, 0, 0, 0);
    tbl[15] = mk(2'b00, 0, 64'h0,    0, 64'h0,  0,  0,  0,  3,  4, 64'hA,   64'h0, 0, 0, 0);

    set_idle();
    model_reset();
    rst = 1'b1;
    rd_addr = {AW'(7), AW'(5)};
    #2;
    chk("rst_d0", rd_data[XLEN-1:0], 64'h0);
    chk("rst_pany", XLEN'(pend_any), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table from a clean reset state.
    for (int k = 0; k < 16; k++) begin
      wr_en = tbl[k].wen;
      wr_addr = {tbl[k].wa1, tbl[k].wa0};
      wr_data = {tbl[k].wd1, tbl[k].wd0};
      iss_en = tbl[k].iss; iss_addr = tbl[k].ia; flush = tbl[k].fl;
      rd_addr = {tbl[k].ra1, tbl[k].ra0};
      @(negedge clk);
      chk($sformatf("vec%0d_d0", k), rd_data[XLEN-1:0], tbl[k].ed0);
      chk($sformatf("vec%0d_d1", k), rd_data[2*XLEN-1:XLEN], tbl[k].ed1);
      chk($sformatf("vec%0d_b0", k), XLEN'(rd_busy[0]), XLEN'(tbl[k].eb0));
      chk($sformatf("vec%0d_b1", k), XLEN'(rd_busy[1]), XLEN'(tbl[k].eb1));
      chk($sformatf("vec%0d_pany", k), XLEN'(pend_any), XLEN'(tbl[k].epa));
      edge_step();
    end

    // Asynchronous reset mid-operation, with a forwarding write in flight.
    set_idle();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {64'h0, 64'hDEAD};
    iss_en = 1'b1; iss_addr = AW'(6);
    edge_step();
    set_idle();
    rd_addr = {AW'(6), AW'(5)};
    @(negedge clk);
    chk("pre_rst_d0", rd_data[XLEN-1:0], 64'hDEAD);
    chk("pre_rst_b1", XLEN'(rd_busy[1]), 64'h1);
    chk("pre_rst_pany", XLEN'(pend_any), 64'h1);
    edge_step();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {64'h0, 64'h1234};
    rst = 1'b1;
    #1;
    chk("async_rst_d0", rd_data[XLEN-1:0], 64'h0);
    chk("async_rst_b0", XLEN'(rd_busy[0]), 64'h0);
    chk("async_rst_b1", XLEN'(rd_busy[1]), 64'h0);
    chk("async_rst_pany", XLEN'(pend_any), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_idle();
    rd_addr = {AW'(6), AW'(5)};
    @(negedge clk);
    chk("post_rst_x5", rd_data[XLEN-1:0], 64'h0);
    chk("post_rst_b1", XLEN'(rd_busy[1]), 64'h0);
    edge_step();

    // Randomized traffic; small address pool to force collisions and forwarding.
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a0, a1, r0, r1, ia;
      a0 = AW'($urandom_range(0, 7)); a1 = AW'($urandom_range(0, 7));
      r0 = AW'($urandom_range(0, 7)); r1 = AW'($urandom_range(0, 31));
      ia = AW'($urandom_range(0, 7));
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {a1, a0};
      wr_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = ia;
      flush = ($urandom_range(0, 15) == 0);
      rd_addr = {r1, r0};
      @(negedge clk);
      model_check("rnd");
      edge_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
